datapath_core: RTL and testbench



---
 rtl/datapath_core.sv | 148 ++++++++++++++
 tb/tb_datapath_core.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/datapath_core.sv
// RV64 single-cycle fetch/decode front end: program counter, instruction memory,
// a register file preloaded on reset, and main/ALU control decode with local BEQ resolution.

module DatapathFetch #(
  parameter int IMEM_WORDS = 64,
  parameter int XLEN       = 64,
  parameter int AW         = $clog2(IMEM_WORDS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            branchTaken_i,
  input  logic [XLEN-1:0] branchOffset_i,
  input  logic            imemWe_i,
  input  logic [AW-1:0]   imemWaddr_i,
  input  logic [31:0]     imemWdata_i,
  output logic [31:0]     instr_o
);

  logic [XLEN-1:0] PC;
  logic [XLEN-1:0] pcNext_d;
  logic [31:0]     instr_mem [0:IMEM_WORDS-1];

  // Upper PC bits are carried along but only the word index addresses memory.
  assign instr_o = instr_mem[PC[AW+1:2]];

  always_comb begin
    pcNext_d = PC + XLEN'(4);
    if (branchTaken_i) pcNext_d = PC + branchOffset_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) PC <= '0;
    else        PC <= pcNext_d;
  end

  // Memory is never reset; normally preloaded, with this port available for a loader.
  always_ff @(posedge clk) begin
    if (imemWe_i) instr_mem[imemWaddr_i] <= imemWdata_i;
  end

endmodule

module datapath_core #(
  parameter int IMEM_WORDS = 64,
  parameter int XLEN       = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic [4:0]      write_addr,
  output logic [3:0]      alu_control_signal,
  output logic            RegWrite,
  output logic            MemRead,
  output logic            MemtoReg,
  output logic            MemWrite,
  output logic            Branch
);

  localparam int AW = $clog2(IMEM_WORDS);

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_SD    = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  logic [31:0]     instr;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            funct7b5;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic            branchTaken;
  logic [XLEN-1:0] branchOffset;
  logic [XLEN-1:0] regs_q [0:31];

  DatapathFetch #(
    .IMEM_WORDS(IMEM_WORDS),
    .XLEN      (XLEN),
    .AW        (AW)
  ) IF_stage (
    .clk           (clk),
    .rst_n         (rst_n),
    .branchTaken_i (branchTaken),
    .branchOffset_i(branchOffset),
    .imemWe_i      (1'b0),
    .imemWaddr_i   ({AW{1'b0}}),
    .imemWdata_i   (32'h0),
    .instr_o       (instr)
  );

  assign opcode     = instr[6:0];
  assign funct3     = instr[14:12];
  assign funct7b5   = instr[30];
  assign rs1        = instr[19:15];
  assign rs2        = instr[24:20];
  assign write_addr = instr[11:7];

  // No write path exists here, so the file only ever holds its reset pattern x[i] = i*10.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= XLEN'(i * 10);
    end
  end

  assign rd1 = (rs1 == 5'd0) ? '0 : regs_q[rs1];
  assign rd2 = (rs2 == 5'd0) ? '0 : regs_q[rs2];

  assign branchOffset = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign branchTaken  = Branch && (rd1 == rd2);

  always_comb begin
    RegWrite           = 1'b0;
    MemRead            = 1'b0;
    MemtoReg           = 1'b0;
    MemWrite           = 1'b0;
    Branch             = 1'b0;
    alu_control_signal = 4'b0000;
    unique case (opcode)
      OP_RTYPE: begin
        RegWrite = 1'b1;
        case ({funct7b5, funct3})
          4'b0_000: alu_control_signal = 4'b0010;
          4'b1_000: alu_control_signal = 4'b0110;
          4'b0_111: alu_control_signal = 4'b0000;
          4'b0_110: alu_control_signal = 4'b0001;
          default:  alu_control_signal = 4'b0000;
        endcase
      end
      OP_LD: begin
        RegWrite           = 1'b1;
        MemRead            = 1'b1;
        MemtoReg           = 1'b1;
        alu_control_signal = 4'b0010;
      end
      OP_SD: begin
        MemWrite           = 1'b1;
        alu_control_signal = 4'b0010;
      end
      OP_BEQ: begin
        Branch             = 1'b1;
        alu_control_signal = 4'b0110;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_datapath_core.sv
// Self-checking bench for datapath_core: decode table via forced PC, free-running PC
// sequence with and without a taken branch, and asynchronous reset between edges.

module tb_datapath_core;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] rd1;
    logic [63:0] rd2;
    logic [4:0]  wa;
    logic [4:0]  ctrl;
    logic [3:0]  alu;
  } dec_exp_t;

  logic        clk;
  logic        rst_n;
  logic [63:0] rd1;
  logic [63:0] rd2;
  logic [4:0]  write_addr;
  logic [3:0]  alu_control_signal;
  logic        RegWrite;
  logic        MemRead;
  logic        MemtoReg;
  logic        MemWrite;
  logic        Branch;

  logic [63:0] forcePc;
  int          testsRun;
  int          testsFailed;
  dec_exp_t    expQ[$];
  logic [63:0] pcQ[$];

  datapath_core dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .rd1               (rd1),
    .rd2               (rd2),
    .write_addr        (write_addr),
    .alu_control_signal(alu_control_signal),
    .RegWrite          (RegWrite),
    .MemRead           (MemRead),
    .MemtoReg          (MemtoReg),
    .MemWrite          (MemWrite),
    .Branch            (Branch)
  );

  always #5 clk = ~clk;

  task automatic load_program();
    for (int i = 0; i < 64; i++) dut.IF_stage.instr_mem[i] = 32'h0;
    dut.IF_stage.instr_mem[0] = 32'h00000033;
    dut.IF_stage.instr_mem[1] = 32'h40000033;
    dut.IF_stage.instr_mem[2] = 32'h0102B083;
    dut.IF_stage.instr_mem[3] = 32'h0041A423;
    dut.IF_stage.instr_mem[4] = 32'h00628A63;
    dut.IF_stage.instr_mem[5] = 32'h009463B3;
    dut.IF_stage.instr_mem[6] = 32'h00C5F533;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    testsRun++;
    if (dut.IF_stage.PC !== 64'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_pc: got %h expected %h", dut.IF_stage.PC, 64'h0);
    end
    testsRun++;
    if ({RegWrite, MemRead, MemtoReg, MemWrite, Branch, alu_control_signal} !== 9'b10000_0010) begin
      testsFailed++;
      $display("[TB] FAIL reset_decode: got %b expected %b",
               {RegWrite, MemRead, MemtoReg, MemWrite, Branch, alu_control_signal}, 9'b10000_0010);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_decode();
    dec_exp_t e;
    expQ.push_back('{64'h00,  64'd0,   64'd0,   5'd0,  5'b10000, 4'b0010});
    expQ.push_back('{64'h04,  64'd0,   64'd0,   5'd0,  5'b10000, 4'b0110});
    expQ.push_back('{64'h08,  64'd50,  64'd160, 5'd1,  5'b11100, 4'b0010});
    expQ.push_back('{64'h0C,  64'd30,  64'd40,  5'd8,  5'b00010, 4'b0010});
    expQ.push_back('{64'h10,  64'd50,  64'd60,  5'd20, 5'b00001, 4'b0110});
    expQ.push_back('{64'h14,  64'd80,  64'd90,  5'd7,  5'b10000, 4'b0001});
    expQ.push_back('{64'h18,  64'd110, 64'd120, 5'd10, 5'b10000, 4'b0000});
    expQ.push_back('{64'h40,  64'd0,   64'd0,   5'd0,  5'b00000, 4'b0000});
    expQ.push_back('{64'h108, 64'd50,  64'd160, 5'd1,  5'b11100, 4'b0010});
    @(negedge clk);
    forcePc = 64'h0;
    force dut.IF_stage.PC = forcePc;
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      forcePc = e.pc;
      #1;
      testsRun++;
      if (rd1 !== e.rd1) begin
        testsFailed++;
        $display("[TB] FAIL decode_rd1 pc=%h: got %0d expected %0d", e.pc, rd1, e.rd1);
      end
      testsRun++;
      if (rd2 !== e.rd2) begin
        testsFailed++;
        $display("[TB] FAIL decode_rd2 pc=%h: got %0d expected %0d", e.pc, rd2, e.rd2);
      end
      testsRun++;
      if (write_addr !== e.wa) begin
        testsFailed++;
        $display("[TB] FAIL decode_waddr pc=%h: got %0d expected %0d", e.pc, write_addr, e.wa);
      end
      testsRun++;
      if ({RegWrite, MemRead, MemtoReg, MemWrite, Branch, alu_control_signal} !== {e.ctrl, e.alu}) begin
        testsFailed++;
        $display("[TB] FAIL decode_ctrl pc=%h: got %b expected %b", e.pc,
                 {RegWrite, MemRead, MemtoReg, MemWrite, Branch, alu_control_signal}, {e.ctrl, e.alu});
      end
      @(negedge clk);
    end
    release dut.IF_stage.PC;
  endtask

  task automatic test_free_run();
    logic [63:0] expPc;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) pcQ.push_back(64'(i * 4));
    pcQ.push_back(64'h14);
    pcQ.push_back(64'h18);
    while (pcQ.size() > 0) begin
      #1;
      expPc = pcQ.pop_front();
      testsRun++;
      if (dut.IF_stage.PC !== expPc) begin
        testsFailed++;
        $display("[TB] FAIL free_run_pc: got %h expected %h", dut.IF_stage.PC, expPc);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_branch_taken();
    logic [63:0] expPc;
    dut.IF_stage.instr_mem[4] = 32'h00000463;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) pcQ.push_back(64'(i * 4));
    pcQ.push_back(64'h18);
    pcQ.push_back(64'h1C);
    while (pcQ.size() > 0) begin
      #1;
      expPc = pcQ.pop_front();
      testsRun++;
      if (dut.IF_stage.PC !== expPc) begin
        testsFailed++;
        $display("[TB] FAIL branch_taken_pc: got %h expected %h", dut.IF_stage.PC, expPc);
      end
      @(negedge clk);
    end
    dut.IF_stage.instr_mem[4] = 32'h00628A63;
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    testsRun++;
    if (dut.IF_stage.PC !== 64'h0) begin
      testsFailed++;
      $display("[TB] FAIL async_reset_pc: got %h expected %h", dut.IF_stage.PC, 64'h0);
    end
    testsRun++;
    if (alu_control_signal !== 4'b0010) begin
      testsFailed++;
      $display("[TB] FAIL async_reset_alu: got %b expected %b", alu_control_signal, 4'b0010);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    testsRun++;
    if (dut.IF_stage.PC !== 64'h0) begin
      testsFailed++;
      $display("[TB] FAIL async_reset_hold: got %h expected %h", dut.IF_stage.PC, 64'h0);
    end
  endtask

  initial begin
    clk         = 1'b0;
    rst_n       = 1'b1;
    forcePc     = 64'h0;
    testsRun    = 0;
    testsFailed = 0;
    load_program();
    #2;
    test_reset();
    test_decode();
    test_free_run();
    test_branch_taken();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
